// File: rtl/gps_ack_pkg.sv
// rtl/gps_ack_pkg.sv - shared constants, result record and search state for the GPS acquisition peak search
package gps_ack_pkg;

    localparam int MAG_W      = 12;
    localparam int NUM_CH     = 4;
    localparam int NUM_PHASES = 1024;
    localparam int MAG_BIAS   = 2048;

    typedef struct packed {
        logic [5:0]       sat;
        logic [9:0]       phase;
        logic [MAG_W-1:0] peak;
        logic             acq;
    } peak_res_t;

    typedef enum logic {
        IDLE,
        SEARCH
    } search_state_t;

endpackage

// File: rtl/gps_peak_track.sv
// rtl/gps_peak_track.sv - per-channel magnitude, best-peak tracking and acquisition decision (GPS_ACK_PEAK_SECOND_EN adds second-best)
module gps_peak_track
    import gps_ack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic [9:0]       ph,
    input  logic [11:0]      integ,
    input  logic [MAG_W-1:0] thr,
    input  logic [MAG_W-1:0] margin,
    output logic [MAG_W-1:0] best_nx,
    output logic [9:0]       best_ph_nx,
    output logic             acq_nx
);

    logic [12:0]      diff;
    logic [MAG_W-1:0] mag;
    logic             take;
    logic [MAG_W-1:0] best_q, best_d;
    logic [9:0]       best_ph_q, best_ph_d;

    // Magnitude about the bias, then best update; phase 0 restarts the search so ties keep the earliest phase
    always_comb begin
        diff      = {1'b0, integ} - 13'(MAG_BIAS);
        mag       = diff[12] ? MAG_W'(-diff) : MAG_W'(diff);
        take      = upd && ((ph == 10'd0) || (mag > best_q));
        best_d    = take ? mag : best_q;
        best_ph_d = take ? ph : best_ph_q;
    end

    assign best_nx    = best_d;
    assign best_ph_nx = best_ph_d;

    // Best magnitude and its phase
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            best_q    <= '0;
            best_ph_q <= '0;
        end else begin
            best_q    <= best_d;
            best_ph_q <= best_ph_d;
        end
    end

`ifdef GPS_ACK_PEAK_SECOND_EN
    logic [MAG_W-1:0] second_q, second_d;

    // Second-best takes a demoted best or a value that beats second but not best
    always_comb begin
        second_d = second_q;
        if (upd && (ph == 10'd0)) begin
            second_d = '0;
        end else if (take) begin
            second_d = best_q;
        end else if (upd && (mag > second_q)) begin
            second_d = mag;
        end
        acq_nx = (best_d >= thr) && ((best_d - second_d) >= margin);
    end

    // Second-best magnitude
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            second_q <= '0;
        end else begin
            second_q <= second_d;
        end
    end
`else
    logic unused_margin;
    assign unused_margin = ^margin;

    // Threshold-only decision on the post-update best
    always_comb begin
        acq_nx = (best_d >= thr);
    end
`endif

endmodule

// File: rtl/gps_ack_peak.sv
// rtl/gps_ack_peak.sv - GPS acquisition peak search top: edge detect, scan FSM, group buffer and drain; macro GPS_ACK_PEAK_SECOND_EN
module gps_ack_peak
    import gps_ack_pkg::*;
#(
    parameter int MAG_W      = 12,
    parameter int NUM_GROUPS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ack_start,
    input  logic             corr_complete,
    input  logic [9:0]       code_phase,
    input  logic [5:0]       sat0,
    input  logic [5:0]       sat1,
    input  logic [5:0]       sat2,
    input  logic [5:0]       sat3,
    input  logic [11:0]      integrator_0,
    input  logic [11:0]      integrator_1,
    input  logic [11:0]      integrator_2,
    input  logic [11:0]      integrator_3,
    input  logic [MAG_W-1:0] thr,
    input  logic [MAG_W-1:0] margin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [5:0]       res_sat,
    output logic [9:0]       res_phase,
    output logic [MAG_W-1:0] res_peak,
    output logic             res_acq,
    output logic             scan_done,
    output logic             overrun
);

    localparam int GW = $clog2(NUM_GROUPS + 1);

    logic [5:0]       sat_arr   [NUM_CH];
    logic [11:0]      integ_arr [NUM_CH];
    logic [MAG_W-1:0] best_nx   [NUM_CH];
    logic [9:0]       ph_nx     [NUM_CH];
    logic             acq_nx    [NUM_CH];

    search_state_t state_q, state_d;
    logic          cc_q;
    logic [GW-1:0] grp_q, grp_d;
    peak_res_t     rbuf_q [NUM_CH];
    peak_res_t     rbuf_d [NUM_CH];
    logic [1:0]    idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          final_q, final_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;

    logic       strobe, active, grp_end, hs, last_hs;
    logic [9:0] ph;

    assign sat_arr[0]   = sat0;
    assign sat_arr[1]   = sat1;
    assign sat_arr[2]   = sat2;
    assign sat_arr[3]   = sat3;
    assign integ_arr[0] = integrator_0;
    assign integ_arr[1] = integrator_1;
    assign integ_arr[2] = integrator_2;
    assign integ_arr[3] = integrator_3;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_trk
        gps_peak_track u_trk (
            .clk        (clk),
            .rst        (rst),
            .clr        (ack_start),
            .upd        (active),
            .ph         (ph),
            .integ      (integ_arr[ch]),
            .thr        (thr),
            .margin     (margin),
            .best_nx    (best_nx[ch]),
            .best_ph_nx (ph_nx[ch]),
            .acq_nx     (acq_nx[ch])
        );
    end

    // Strobe qualification, group-end snapshot, drain stepping and scan sequencing
    always_comb begin
        strobe  = corr_complete & ~cc_q;
        ph      = code_phase - 10'd1;
        active  = strobe && (state_q == SEARCH) && !ack_start;
        grp_end = active && (ph == 10'(NUM_PHASES - 1));
        hs      = valid_q && res_ready;
        last_hs = hs && (idx_q == 2'd3);

        state_d = state_q;
        grp_d   = grp_q;
        rbuf_d  = rbuf_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        final_d = final_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;

        if (hs) begin
            if (idx_q == 2'd3) begin
                valid_d = 1'b0;
                idx_d   = 2'd0;
                if (final_q) begin
                    done_d  = 1'b1;
                    final_d = 1'b0;
                end
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end

        if (grp_end) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                rbuf_d[ch] = '{sat: sat_arr[ch], phase: ph_nx[ch], peak: best_nx[ch], acq: acq_nx[ch]};
            end
            valid_d = 1'b1;
            idx_d   = 2'd0;
            if (valid_q && !last_hs) begin
                ovr_d = 1'b1;
            end
            grp_d = grp_q + 1'b1;
            if ((grp_q + 1'b1) == GW'(NUM_GROUPS)) begin
                state_d = IDLE;
                final_d = 1'b1;
            end
        end

        if (ack_start) begin
            state_d = SEARCH;
            grp_d   = '0;
            rbuf_d  = '{default: '0};
            idx_d   = 2'd0;
            valid_d = 1'b0;
            final_d = 1'b0;
            done_d  = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // All top-level state including the search FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cc_q    <= 1'b0;
            grp_q   <= '0;
            rbuf_q  <= '{default: '0};
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            final_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cc_q    <= corr_complete;
            grp_q   <= grp_d;
            rbuf_q  <= rbuf_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            final_q <= final_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign res_valid = valid_q;
    assign res_sat   = rbuf_q[idx_q].sat;
    assign res_phase = rbuf_q[idx_q].phase;
    assign res_peak  = rbuf_q[idx_q].peak;
    assign res_acq   = rbuf_q[idx_q].acq;
    assign scan_done = done_q;
    assign overrun   = ovr_q;

endmodule
